// File: rtl/rr_packet_arbiter_if.sv
// Handshake bundle between the flit sources, the round-robin packet arbiter
// and the downstream output channel.
// master: source/sink side (drives flits and out_ready).
// slave : arbiter side.
// The pkt_cnt bus exists only when ARB_STATS_EN is defined.
interface rr_packet_arbiter_if #(
  parameter int N_IN   = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [N_IN-1:0]        in_valid;
  logic [N_IN-1:0]        in_last;
  logic [N_IN*DATA_W-1:0] in_data;
  logic [N_IN-1:0]        in_ready;
  logic                   out_valid;
  logic                   out_last;
  logic [DATA_W-1:0]      out_data;
  logic                   out_ready;
  logic [IDX_W-1:0]       grant_idx;
  logic                   locked;
`ifdef ARB_STATS_EN
  logic [N_IN*CNT_W-1:0]  pkt_cnt;

  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, grant_idx, locked, pkt_cnt
  );
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, grant_idx, locked, pkt_cnt
  );
`else
  modport master (
    output in_valid, in_last, in_data, out_ready,
    input  in_ready, out_valid, out_last, out_data, grant_idx, locked
  );
  modport slave (
    input  in_valid, in_last, in_data, out_ready,
    output in_ready, out_valid, out_last, out_data, grant_idx, locked
  );
`endif
endinterface

// File: rtl/rr_packet_arbiter.sv
// N-input round-robin packet arbiter for the mesh router output stage.
// Zero-latency passthrough with valid/ready on every port; a grant is held
// (wormhole lock) from the head flit to the tail flit of a packet, and a
// flit stalled by backpressure keeps its grant until accepted.
// Optional: define ARB_STATS_EN for per-input saturating completed-packet
// counters on the pkt_cnt bus.
module rr_packet_arbiter #(
  parameter int N_IN   = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  rr_packet_arbiter_if.slave bus
);
  localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);
  localparam logic [IDX_W:0]   N_WIDE   = (IDX_W + 1)'(N_IN);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;

  logic [IDX_W-1:0] win;       // round-robin winner among valid inputs
  logic             any_vld;   // at least one input valid
  logic [IDX_W:0]   cand;      // scan position before modulo fold
  logic             is_locked;
  logic [IDX_W-1:0] sel;       // input currently steering the output mux
  logic             vld;
  logic             lst;
  logic             xfer;
  logic [N_IN-1:0]  rdy;
  logic [DATA_W-1:0] lane_data [N_IN];

  // Next pointer value; explicit wrap so non-power-of-two N_IN works.
  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] x);
    return (x >= LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  // Unflatten the input flit bus into one word per lane.
  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    assign lane_data[g] = bus.in_data[g*DATA_W +: DATA_W];
  end

  // Winner search: first valid input scanning ptr, ptr+1, ... modulo N_IN.
  always_comb begin
    win     = '0;
    any_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < N_IN; k++) begin
      cand = {1'b0, ptr_q} + (IDX_W + 1)'(k);
      if (cand >= N_WIDE) cand = cand - N_WIDE;
      if (!any_vld && bus.in_valid[cand[IDX_W-1:0]]) begin
        any_vld = 1'b1;
        win     = cand[IDX_W-1:0];
      end
    end
  end

  assign is_locked = (state_q == ST_LOCKED);
  assign sel       = is_locked ? owner_q : win;
  // Reset forces the handshake quiet so nothing moves mid-reset.
  assign vld       = !rst && (is_locked ? bus.in_valid[owner_q] : any_vld);
  assign lst       = bus.in_last[sel];
  assign xfer      = vld && bus.out_ready;

  // Only the selected input sees out_ready; everyone else is held off.
  always_comb begin
    rdy = '0;
    if (!rst && (is_locked || any_vld)) rdy[sel] = bus.out_ready;
  end

  assign bus.out_valid = vld;
  assign bus.out_last  = lst;
  assign bus.out_data  = lane_data[sel];
  assign bus.in_ready  = rdy;
  assign bus.grant_idx = sel;
  assign bus.locked    = is_locked;

  // Lock/priority control: IDLE grants on the fly, LOCKED holds until tail.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (state_q == ST_IDLE) begin
      if (vld) begin
        if (xfer && lst) begin
          // Single-flit packet: done in one cycle, rotate past the winner.
          ptr_d = wrap_inc(win);
        end else begin
          // Multi-flit head or stalled flit: freeze the selection.
          state_d = ST_LOCKED;
          owner_d = win;
        end
      end
    end else if (xfer && lst) begin
      state_d = ST_IDLE;
      ptr_d   = wrap_inc(owner_q);
    end
  end

  // State, pointer and owner registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [N_IN-1:0][CNT_W-1:0] cnt_q;

  for (genvar g = 0; g < N_IN; g++) begin : g_cnt
    logic [CNT_W-1:0] cnt_d;
    // Count tail transfers from this input, sticking at all-ones.
    always_comb begin
      cnt_d = cnt_q[g];
      if (xfer && lst && (sel == IDX_W'(g)) && (cnt_q[g] != '1))
        cnt_d = cnt_q[g] + 1'b1;
    end
    // Per-input packet counter register.
    always_ff @(posedge clk) begin
      if (rst) cnt_q[g] <= '0;
      else     cnt_q[g] <= cnt_d;
    end
  end

  assign bus.pkt_cnt = cnt_q;
`endif

  // At most one input is ever offered ready.
  a_rdy_onehot: assert property (@(posedge clk) $onehot0(rdy));

  // A stalled flit keeps its grant on the following cycle.
  a_stall_hold: assert property (@(posedge clk) disable iff (rst)
    (vld && !bus.out_ready) |=> (rst || sel == $past(sel)));

endmodule
